// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 decryption key scheduler.
//   state_e   : controller states
//   RCON      : round constants Rcon[1..7] (top byte of the word)
//   SBOX      : forward AES S-box table
//   rcon_byte : Rcon lookup that returns 0 for index 0
//   rot_word  : RotWord, rotate one byte left
//   sub_word  : SubWord, S-box applied to each byte
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    EMIT
  } state_e;

  localparam logic [1:7][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon_byte(input logic [2:0] i);
    logic [7:0] r;
    r = '0;
    for (int unsigned j = 1; j <= 7; j++) begin
      if (i == 3'(j)) r = RCON[j];
    end
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Byte-wide forward AES S-box (table lookup).
//   din  : input byte
//   dout : substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  always_comb begin
    dout = SBOX[din];
  end

endmodule

// File: rtl/aes256_inv_key_sched.sv
// AES-256 decryption key scheduler. Expands the cipher key forward to the
// last 8-word window, then steps the schedule backwards one window at a
// time, streaming round keys 14 down to 0 over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load key_in and begin (sampled in IDLE only)
//   key_in     : cipher key, w0 in [255:224] .. w7 in [31:0]
//   busy       : job in progress
//   rk_valid   : rk_data/rk_idx hold a round key
//   rk_ready   : consumer accepts the round key
//   rk_data    : round key, first word in [127:96]
//   rk_idx     : round number of rk_data (14..0)
//   done       : one-cycle pulse after the round-0 transfer
module aes256_inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         done
);

  state_e       state_q, state_d;
  logic [255:0] win_q, win_d;
  logic [2:0]   k_q, k_d;
  logic         hi_q, hi_d;
  logic         done_q, done_d;

  logic         fwd_sel;
  logic [2:0]   rcon_i;
  logic [31:0]  rcon_w;
  logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7;
  logic [31:0]  p7;
  logic [31:0]  rot_in, rot_out, mid_in, mid_out;
  logic [31:0]  x0, x1, x2, x3, x4, x5, x6, x7;
  logic [255:0] fwd_win, inv_win;

  assign {w0, w1, w2, w3, w4, w5, w6, w7} = win_q;

  assign fwd_sel = (state_q == EXPAND);
  assign rcon_i  = fwd_sel ? k_q + 3'd1 : k_q;
  assign rcon_w  = {rcon_byte(rcon_i), 24'h0};

  // One shared set of 8 S-boxes; only their inputs change with direction,
  // so a cycle never carries both a forward and an inverse step.
  assign p7     = w7 ^ w6;
  assign rot_in = fwd_sel ? rot_word(w7) : rot_word(p7);

  // Word 0 and word 4 are the same XOR in both directions (n0 = w0^t,
  // p0 = w0^SubWord(RotWord(p7))^Rcon); only the S-box operands differ.
  assign x0 = w0 ^ rot_out ^ rcon_w;
  assign x1 = w1 ^ x0;
  assign x2 = w2 ^ x1;
  assign x3 = w3 ^ x2;

  assign mid_in = fwd_sel ? x3 : w3;

  assign x4 = w4 ^ mid_out;
  assign x5 = w5 ^ x4;
  assign x6 = w6 ^ x5;
  assign x7 = w7 ^ x6;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox_rot (
      .din  (rot_in[8*i +: 8]),
      .dout (rot_out[8*i +: 8])
    );
    aes_sbox u_sbox_mid (
      .din  (mid_in[8*i +: 8]),
      .dout (mid_out[8*i +: 8])
    );
  end

  assign fwd_win = {x0, x1, x2, x3, x4, x5, x6, x7};
  assign inv_win = {x0, w1 ^ w0, w2 ^ w1, w3 ^ w2, x4, w5 ^ w4, w6 ^ w5, p7};

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    k_d     = k_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          win_d   = key_in;
          k_d     = '0;
          hi_d    = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        win_d = fwd_win;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd6) begin
          hi_d    = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (!hi_q) begin
            hi_d = 1'b1;
          end else if (k_q != '0) begin
            win_d = inv_win;
            k_d   = k_q - 3'd1;
            hi_d  = 1'b0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      k_q     <= '0;
      hi_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      k_q     <= k_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign rk_data  = rk_valid ? (hi_q ? win_q[255:128] : win_q[127:0]) : '0;
  assign rk_idx   = rk_valid ? {k_q, ~hi_q} : '0;
  assign done     = done_q;

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
module tb_aes256_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         done;

  always #5 clk = ~clk;

  aes256_inv_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    logic [255:0] key;
    logic [3:0]   idx;
    logic [127:0] data;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[4];
  logic [7:0]   sbox_t[256];
  logic [127:0] got[16];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           ready_mode = 1;
  int           t_start = 0;
  int           t_first_valid = -1;
  int           t_done = 0;
  int           done_cnt = 0;
  logic         busy_at_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ a;
      a = xtime(a);
    end
    return r;
  endfunction

  // S-box derived from GF(2^8) inverse plus affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = '0;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  // Golden forward key expansion; queues the expected 14..0 stream.
  task automatic push_job(input logic [255:0] key);
    logic [31:0] w[60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    exp_t        e;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xtime(rc);
      end else if (i % 8 == 4) begin
        tmp = sub_w(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 14; r >= 0; r--) begin
      e.idx  = 4'(r);
      e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      sb.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t         e;
    logic         stall;
    logic [131:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        stall = 1'b0;
        continue;
      end
      if (stall) check("stall_hold", {rk_valid, rk_idx, rk_data}, {1'b1, held});
      if (done) begin
        done_cnt++;
        t_done = cyc;
        busy_at_done = busy;
        check("done_queue_empty", sb.size(), 0);
      end
      if (rk_valid && rk_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_xfer: got idx %0d, required no transfer", rk_idx);
        end else begin
          e = sb.pop_front();
          check("rk_idx", rk_idx, e.idx);
          check("rk_data", rk_data, e.data);
          got[rk_idx] = rk_data;
        end
      end
      if (start && !busy) begin
        t_start = cyc;
        t_first_valid = -1;
        for (int i = 0; i < 16; i++) got[i] = '0;
        push_job(key_in);
      end
      if (rk_valid && t_first_valid < 0) t_first_valid = cyc;
      stall = rk_valid && !rk_ready;
      held  = {rk_idx, rk_data};
    end
  endtask

  task automatic ready_drv();
    rk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) rk_ready = ($urandom_range(0, 99) < 30);
      else rk_ready = (ready_mode == 1);
    end
  endtask

  task automatic launch(input logic [255:0] k);
    @(posedge clk);
    #1;
    key_in = k;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_cycle1", busy, 1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s: done not seen within %0d cycles", name, budget);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rk_valid"}, rk_valid, 0);
    check({tag, "_rk_data"}, rk_data, 0);
    check({tag, "_rk_idx"}, rk_idx, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run_table(input int mode, input string tag);
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || vecs[i].key != vecs[i-1].key) begin
        ready_mode = mode;
        launch(vecs[i].key);
        wait_done(400, {tag, "_done"});
      end
      check({tag, "_vec_rk", $sformatf("%0d", vecs[i].idx)}, got[vecs[i].idx], vecs[i].data);
    end
  endtask

  initial begin
    int           d0;
    int           t0;
    logic [255:0] k;
    logic         found;

    vecs[0] = '{key: KEY_A3, idx: 4'd14, data: 128'hfe4890d1e6188d0b046df344706c631e};
    vecs[1] = '{key: KEY_A3, idx: 4'd2,  data: 128'h9ba354118e6925afa51a8b5f2067fcde};
    vecs[2] = '{key: KEY_A3, idx: 4'd1,  data: 128'h1f352c073b6108d72d9810a30914dff4};
    vecs[3] = '{key: KEY_A3, idx: 4'd0,  data: 128'h603deb1015ca71be2b73aef0857d7781};

    build_sbox();
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    fork
      monitor();
      ready_drv();
      begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero("idle");

    // FIPS-197 A.3 with consumer always ready: exact cycle positions.
    d0 = done_cnt;
    run_table(1, "a3_ready");
    check("a3_first_valid_cycle", t_first_valid - t_start, 8);
    check("a3_done_cycle", t_done - t_start, 23);
    check("a3_busy_at_done", busy_at_done, 0);
    check("a3_done_count", done_cnt - d0, 1);

    // Same key, consumer ready 30% of the time.
    run_table(2, "a3_stall");

    // Boundary keys then random keys.
    for (int r = 0; r < 202; r++) begin
      if (r == 0) k = '0;
      else if (r == 1) k = '1;
      else for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
      ready_mode = (r % 2 == 0) ? 1 : 2;
      launch(k);
      wait_done(400, "rand_done");
    end

    // start pulses during EXPAND and EMIT are ignored.
    ready_mode = 1;
    d0 = done_cnt;
    launch(KEY_A3);
    repeat (2) @(posedge clk);
    #1;
    key_in = {8{32'h11111111}};
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    key_in = {8{32'hdeadbeef}};
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40, "ignore_done");
    check("ignore_done_cycle", t_done - t_start, 23);
    repeat (10) @(negedge clk);
    check("ignore_single_done", done_cnt - d0, 1);
    check("ignore_vec_rk0", got[0], vecs[3].data);

    // Reset asserted while round key 9 is presented.
    ready_mode = 1;
    launch(KEY_A3);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      #1;
      if (rk_valid && rk_idx == 4'd9) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_fail++;
      $display("FAIL reset_wait_idx9: rk_idx 9 not seen within 60 cycles");
    end
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("midreset_no_done", done_cnt, d0);
    check_zero("post_reset_idle");
    run_table(1, "after_reset");
    check("after_reset_done_cycle", t_done - t_start, 23);

    // Back-to-back jobs with start held high.
    ready_mode = 1;
    @(posedge clk);
    #1;
    key_in = KEY_A3;
    start  = 1'b1;
    @(negedge clk);
    #1;
    t0 = cyc;
    wait_done(40, "b2b_first_done");
    check("b2b_first_done_cycle", t_done - t0, 23);
    check("b2b_restart_cycle", t_start - t0, 23);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40, "b2b_second_done");
    check("b2b_second_valid_cycle", t_first_valid - t0, 31);
    check("b2b_second_done_cycle", t_done - t0, 46);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
